// File: rtl/sobel_window_gen.sv
// Purpose: turns a raster pixel stream into 3x3 windows for a Sobel stage, using two line buffers.
// Latency: a window is presented one cycle after the pixel that completes it is accepted.
// Backpressure: pixel_ready drops while a window is held and not yet consumed (sobel_done low).
module sobel_window_gen #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 48
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            pixel_in,
    input  logic                  pixel_valid,
    input  logic                  pixel_sof,
    output logic                  pixel_ready,
    output logic [2:0][2:0][7:0]  comp_matrix,
    output logic                  sobel_en,
    input  logic                  sobel_done,
    output logic [9:0]            win_x,
    output logic [9:0]            win_y,
    output logic                  frame_done
);

    localparam int         AW     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [9:0] X_LAST = 10'(IMG_WIDTH - 1);
    localparam logic [9:0] Y_LAST = 10'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STREAM
    } state_t;

    state_t          state;
    logic [9:0]      x;
    logic [9:0]      y;
    logic [9:0]      cur_x;
    logic [9:0]      cur_y;
    logic [9:0]      nxt_x;
    logic [9:0]      nxt_y;
    logic            accept;
    logic            complete;
    logic            last_pix;
    logic [AW-1:0]   rd_idx;

    // lb1 holds row y-1, lb2 holds row y-2
    logic [7:0]      lb1 [0:IMG_WIDTH-1];
    logic [7:0]      lb2 [0:IMG_WIDTH-1];

    // Column vectors indexed by window row: [0]=row y, [1]=row y-1, [2]=row y-2
    logic [2:0][7:0] new_col;
    logic [2:0][7:0] col0;
    logic [2:0][7:0] col1;

    // Ready only depends on whether a held window is still waiting for the consumer
    assign pixel_ready = !(sobel_en && !sobel_done);
    assign accept      = pixel_valid && pixel_ready;

    // A start-of-frame pixel is position (0,0) whatever the counters say
    assign cur_x    = pixel_sof ? '0 : x;
    assign cur_y    = pixel_sof ? '0 : y;
    assign rd_idx   = cur_x[AW-1:0];
    assign new_col  = {lb2[rd_idx], lb1[rd_idx], pixel_in};
    assign complete = (cur_x >= 10'd2) && (cur_y >= 10'd2);
    assign last_pix = (cur_x == X_LAST) && (cur_y == Y_LAST);

    // Raster position of the pixel after the one being accepted
    always_comb begin
        nxt_x = cur_x + 10'd1;
        nxt_y = cur_y;
        if (cur_x == X_LAST) begin
            nxt_x = '0;
            nxt_y = (cur_y == Y_LAST) ? '0 : cur_y + 10'd1;
        end
    end

    // Line buffers: the accepted column shifts down one row; contents survive reset
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            lb2[rd_idx] <= lb1[rd_idx];
            lb1[rd_idx] <= pixel_in;
        end
    end

    // Counters, column shift register and the held window toward the Sobel stage
    always_ff @(posedge clk) begin
        if (rst) begin
            x           <= '0;
            y           <= '0;
            col0        <= '0;
            col1        <= '0;
            sobel_en    <= 1'b0;
            comp_matrix <= '0;
            win_x       <= '0;
            win_y       <= '0;
        end else begin
            if (accept) begin
                x    <= nxt_x;
                y    <= nxt_y;
                col1 <= col0;
                col0 <= new_col;
            end
            if (accept && complete) begin
                sobel_en <= 1'b1;
                for (int r = 0; r < 3; r++) begin
                    comp_matrix[r] <= {col1[r], col0[r], new_col[r]};
                end
                win_x <= cur_x - 10'd1;
                win_y <= cur_y - 10'd1;
            end else if (sobel_done) begin
                sobel_en <= 1'b0;
            end
        end
    end

    // Frame-level state machine; frame_done is a registered one-cycle pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (accept) begin
                if (pixel_sof) begin
                    state <= FILL;
                end else begin
                    case (state)
                        IDLE:    state <= FILL;
                        FILL:    if (nxt_y == 10'd2) state <= STREAM;
                        STREAM: begin
                            if (last_pix) begin
                                state      <= IDLE;
                                frame_done <= 1'b1;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen: a small 4x3 instance for directed cases and a 64x48 one for a random frame.
// Expected windows come from a frame-image model and are queued on accept, popped on consumption.
module tb_sobel_window_gen;

    typedef struct {
        logic [2:0][2:0][7:0] m;
        int                   wx;
        int                   wy;
    } win_t;

    logic clk;
    logic rst;
    logic [7:0] pix;
    logic valid;
    logic sof;
    logic done;
    logic sel;

    logic rdy_s, rdy_l, en_s, en_l, fd_s, fd_l;
    logic [2:0][2:0][7:0] cm_s, cm_l;
    logic [9:0] wx_s, wy_s, wx_l, wy_l;

    logic a_rdy, a_en, a_fd;
    logic [2:0][2:0][7:0] a_cm;
    logic [9:0] a_wx, a_wy;

    int errors = 0;
    int checks = 0;
    win_t exp_q[$];
    logic [7:0] pix_q[$];
    logic sof_q[$];
    logic [7:0] img [0:47][0:63];
    logic [2:0][2:0][7:0] last_exp;
    int W, H, mx, my;
    int cyc = 0;
    int fd_due, fd_cnt, fd_exp, win_cnt, stall_left, stall_cnt;
    bit stall_arm, done_rand, valid_rand, rst_on_complete, rst_hit, first_chk;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sobel_window_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(3)) u_small (
        .clk(clk), .rst(rst), .pixel_in(pix), .pixel_valid(valid && !sel),
        .pixel_sof(sof), .pixel_ready(rdy_s), .comp_matrix(cm_s), .sobel_en(en_s),
        .sobel_done(done), .win_x(wx_s), .win_y(wy_s), .frame_done(fd_s)
    );

    sobel_window_gen #(.IMG_WIDTH(64), .IMG_HEIGHT(48)) u_large (
        .clk(clk), .rst(rst), .pixel_in(pix), .pixel_valid(valid && sel),
        .pixel_sof(sof), .pixel_ready(rdy_l), .comp_matrix(cm_l), .sobel_en(en_l),
        .sobel_done(done), .win_x(wx_l), .win_y(wy_l), .frame_done(fd_l)
    );

    assign a_rdy = sel ? rdy_l : rdy_s;
    assign a_en  = sel ? en_l  : en_s;
    assign a_fd  = sel ? fd_l  : fd_s;
    assign a_cm  = sel ? cm_l  : cm_s;
    assign a_wx  = sel ? wx_l  : wx_s;
    assign a_wy  = sel ? wy_l  : wy_s;

    task automatic check_val(input string tag, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference: keep the current frame as an image and read windows straight out of it
    task automatic model_accept(input logic [7:0] p, input logic s);
        win_t w;
        if (s) begin
            mx = 0;
            my = 0;
        end
        img[my][mx] = p;
        if (mx == W - 1 && my == H - 1) begin
            fd_exp++;
            fd_due = cyc + 1;
        end
        if (mx >= 2 && my >= 2) begin
            if (rst_on_complete) begin
                rst             = 1'b1;
                rst_on_complete = 1'b0;
                rst_hit         = 1'b1;
            end else begin
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        w.m[r][c] = img[my - r][mx - c];
                w.wx = mx - 1;
                w.wy = my - 1;
                exp_q.push_back(w);
            end
        end
        if (mx == W - 1) begin
            mx = 0;
            my = (my == H - 1) ? 0 : my + 1;
        end else begin
            mx = mx + 1;
        end
    endtask

    // One clock: monitor at the falling edge, drive, then sample ready before the rising edge
    task automatic step();
        win_t w;
        @(negedge clk);
        cyc++;
        if (a_en && stall_arm) begin
            stall_left = 5;
            stall_arm  = 1'b0;
        end
        done = (stall_left > 0) ? 1'b0 : (done_rand ? 1'($urandom_range(0, 1)) : 1'b1);
        if (a_fd) begin
            fd_cnt++;
            check_val("frame_done_time", 72'(cyc), 72'(fd_due));
        end
        if (a_en && done) begin
            check_val("window_expected", 72'(exp_q.size() > 0), 72'd1);
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                check_val("matrix", a_cm, w.m);
                check_val("win_x", 72'(a_wx), 72'(w.wx));
                check_val("win_y", 72'(a_wy), 72'(w.wy));
                last_exp = w.m;
                win_cnt++;
                if (first_chk) begin
                    check_val("first_matrix", a_cm, 72'h000102_040506_08090A);
                    check_val("first_win_x", 72'(a_wx), 72'd1);
                    check_val("first_win_y", 72'(a_wy), 72'd1);
                    first_chk = 1'b0;
                end
            end
        end
        if (pix_q.size() > 0 && (!valid_rand || $urandom_range(0, 1) == 1)) begin
            valid = 1'b1;
            pix   = pix_q[0];
            sof   = sof_q[0];
        end else begin
            valid = 1'b0;
            sof   = 1'b0;
        end
        #4;
        if (stall_left > 0) begin
            check_val("stall_ready", 72'(a_rdy), 72'd0);
            if (exp_q.size() > 0) check_val("stall_matrix", a_cm, exp_q[0].m);
            stall_left--;
            stall_cnt++;
        end
        if (valid && a_rdy) begin
            model_accept(pix, sof);
            pix_q.delete(0);
            sof_q.delete(0);
        end
    endtask

    task automatic run(input int drain);
        int guard = 0;
        while ((pix_q.size() > 0 || stall_left > 0) && !rst_hit && guard < 40000) begin
            step();
            guard++;
        end
        check_val("no_timeout", 72'(guard < 40000), 72'd1);
        done_rand = 1'b0;
        if (!rst_hit) repeat (drain) step();
    endtask

    task automatic start(input logic s, input int w, input int h);
        sel = s; W = w; H = h;
        win_cnt = 0; fd_cnt = 0; fd_exp = 0; fd_due = -10; stall_cnt = 0;
        exp_q.delete();
    endtask

    task automatic load_frame(input int w, input int h, input int base, input bit rnd);
        for (int i = 0; i < w * h; i++) begin
            pix_q.push_back(rnd ? 8'($urandom) : 8'(base + i));
            sof_q.push_back(i == 0);
        end
    endtask

    task automatic end_test(input int exp_wins);
        check_val("win_count", 72'(win_cnt), 72'(exp_wins));
        check_val("frame_done_count", 72'(fd_cnt), 72'(fd_exp));
        check_val("queue_empty", 72'(exp_q.size()), 72'd0);
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; sof = 1'b0; pix = '0; done = 1'b1; sel = 1'b0;
        stall_left = 0; stall_arm = 0; done_rand = 0; valid_rand = 0;
        rst_on_complete = 0; rst_hit = 0; first_chk = 0; last_exp = '0;
        mx = 0; my = 0; W = 4; H = 3;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_sobel_en", 72'(a_en), 72'd0);
        check_val("rst_frame_done", 72'(a_fd), 72'd0);
        check_val("rst_matrix", a_cm, 72'd0);
        check_val("rst_win_x", 72'(a_wx), 72'd0);
        check_val("rst_win_y", 72'(a_wy), 72'd0);
        rst = 1'b0;
        #4;
        check_val("ready_after_rst", 72'(a_rdy), 72'd1);

        // 4x3 frame of 0..11, consumer always ready
        start(1'b0, 4, 3);
        load_frame(4, 3, 0, 1'b0);
        first_chk = 1'b1;
        run(8);
        end_test(2);
        check_val("first_frame_done_once", 72'(fd_cnt), 72'd1);

        // Same frame with the consumer stalling five cycles on the first window
        start(1'b0, 4, 3);
        stall_arm = 1'b1;
        load_frame(4, 3, 0, 1'b0);
        run(8);
        end_test(2);
        check_val("stall_cycles", 72'(stall_cnt), 72'd5);

        // Start-of-frame arriving at (2,1) restarts the frame
        start(1'b0, 4, 3);
        for (int i = 0; i < 6; i++) begin
            pix_q.push_back(8'(100 + i));
            sof_q.push_back(i == 0);
        end
        load_frame(4, 3, 200, 1'b0);
        run(8);
        end_test(2);

        // sobel_done toggling while no window is held must not disturb anything
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            done = (i % 2 == 0);
            #4;
            check_val("idle_sobel_en", 72'(a_en), 72'd0);
            check_val("idle_matrix", a_cm, last_exp);
        end
        start(1'b0, 4, 3);
        load_frame(4, 3, 50, 1'b0);
        run(8);
        end_test(2);

        // Reset on the very cycle a window completes
        start(1'b0, 4, 3);
        rst_on_complete = 1'b1;
        load_frame(4, 3, 0, 1'b0);
        run(0);
        @(negedge clk);
        check_val("rstwin_sobel_en", 72'(a_en), 72'd0);
        check_val("rstwin_matrix", a_cm, 72'd0);
        check_val("rstwin_win_x", 72'(a_wx), 72'd0);
        check_val("rstwin_win_y", 72'(a_wy), 72'd0);
        check_val("rstwin_frame_done", 72'(a_fd), 72'd0);
        rst = 1'b0; rst_hit = 1'b0; valid = 1'b0; sof = 1'b0;
        pix_q.delete();
        sof_q.delete();
        start(1'b0, 4, 3);
        load_frame(4, 3, 30, 1'b0);
        run(8);
        end_test(2);

        // Full 64x48 random frame with random valid and random consumer
        start(1'b1, 64, 48);
        valid_rand = 1'b1;
        done_rand  = 1'b1;
        load_frame(64, 48, 0, 1'b1);
        run(10);
        valid_rand = 1'b0;
        end_test(2852);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sobel_window_gen.md
SOBEL_WINDOW_GEN -- requirements
Module: sobel_window_gen

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 64: pixels per line; legal range 3..1024.
REQ-002 SHALL have parameter IMG_HEIGHT, default 48: lines per frame; legal range 3..1024.
REQ-003 Ports, clock and reset first (name direction width meaning):
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous and active-high.
- pixel_in  in  8  raster-order grayscale pixel.
- pixel_valid  in  1  pixel_in is valid this cycle.
- pixel_sof  in  1  start of frame; qualified by pixel_valid.
- pixel_ready  out  1  block accepts pixel this cycle.
- comp_matrix  out  [2:0][2:0][7:0]  3x3 window for the Sobel stage.
- sobel_en  out  1  comp_matrix is valid.
- sobel_done  in  1  Sobel stage consumed the window.
- win_x  out  10  column of window centre pixel.
- win_y  out  10  row of window centre pixel.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-004 Accept = pixel_valid && pixel_ready; nothing changes state on a cycle without accept, except the sobel_en/sobel_done handshake.
REQ-005 pixel_ready SHALL be !(sobel_en && !sobel_done); combinational, no dependence on pixel_valid.
REQ-006 Column counter x runs 0..IMG_WIDTH-1; row counter y runs 0..IMG_HEIGHT-1; both advance on accept; x wraps to 0 and y increments at end of line; both wrap to 0 after (IMG_WIDTH-1, IMG_HEIGHT-1).
REQ-007 An accepted pixel with pixel_sof=1 SHALL be taken as pixel (0,0) regardless of the counters; line buffer contents are not cleared.
REQ-008 Two line buffers of IMG_WIDTH x 8 bits SHALL hold rows y-1 and y-2; on accept at column x, entry x shifts row y-1 -> row y-2 and pixel_in -> row y-1.
REQ-009 Window indexing: comp_matrix[r][c], r=0 row y, r=1 row y-1, r=2 row y-2; c=0 column x, c=1 column x-1, c=2 column x-2.
REQ-010 On accept, the three window columns SHALL shift (c1->c2, c0->c1), and c0 loads {line buffer y-2[x], line buffer y-1[x], pixel_in}.
REQ-011 A window is complete when the accepted pixel has x>=2 and y>=2; no window SHALL be emitted for x<2 or y<2, so windows never straddle a line wrap.
REQ-012 Latency: sobel_en SHALL rise the cycle after the accept that completes a window, with win_x=x-1 and win_y=y-1.
REQ-013 comp_matrix, win_x and win_y SHALL hold stable while sobel_en=1 and sobel_done=0.
REQ-014 sobel_en SHALL clear the cycle after sobel_done=1 unless a new window completes that same cycle, in which case sobel_en stays 1 and the outputs update (back-to-back throughput: 1 window/cycle).
REQ-015 sobel_done while sobel_en=0 SHALL be ignored.
REQ-016 FSM states:
- IDLE: after reset; go to FILL on first accept.
- FILL: y<2; go to STREAM on accept with y reaching 2.
- STREAM: y>=2; go to IDLE after the accept of the last pixel, raising frame_done the next cycle.
- Any accept with pixel_sof=1 SHALL go to FILL from any state.
REQ-017 frame_done SHALL be exactly one cycle long and may coincide with sobel_en for the final window.
REQ-018 Arithmetic: all pixel data is 8-bit unsigned and passes unmodified; there is no arithmetic on pixel values; counters are 10-bit unsigned.

Reset
REQ-019 While rst=1: state=IDLE, x=y=0, sobel_en=0, frame_done=0, comp_matrix=0, win_x=win_y=0, and pixel_ready=1 once the block leaves reset.
REQ-020 Reset mid-frame SHALL drop any pending window (no sobel_en after reset); line buffer contents need not be cleared, and the next frame SHALL start with pixel_sof.

Verification
REQ-021 IMG_WIDTH=4, IMG_HEIGHT=3, pixels 0..11 with sof on the first, valid every cycle, sobel_done tied 1 -> exactly 2 windows; the first has win=(1,1) and comp_matrix rows {10,9,8},{6,5,4},{2,1,0} (r0..r2, c0..c2); frame_done pulses once, one cycle after pixel 11.
REQ-022 Same stream with sobel_done=0 for 5 cycles after the first window -> pixel_ready=0 and comp_matrix is stable during the stall; no pixel is lost, and the second window is centred at (2,1) with correct contents.
REQ-023 Pixel with sof at x=2, y=1 mid-frame -> it is treated as (0,0); no window until row 2, column 2 of the new frame.
REQ-024 rst asserted the cycle a window completes -> sobel_en stays 0 and all outputs are zero the next cycle.
REQ-025 pixel_valid toggled 1/0 randomly over a 64x48 frame -> the window count is 62*46=2852, and every window matches a reference model.
REQ-026 sobel_done pulsed while sobel_en=0 -> no state change.
